// File: rtl/mem_loader.sv
// Boot-time program loader: streams bytes into consecutive memory addresses,
// keeps a running checksum, and holds the core in reset until the image is complete.
module mem_loader #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [DWIDTH-1:0] csum_q, csum_d;
  logic              wr_q, hold_q, busy_q, done_q;

  function automatic logic [DWIDTH-1:0] add_mod(input logic [DWIDTH-1:0] a,
                                                input logic [DWIDTH-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_d = S_WRITE;
          data_d  = in_data;
          addr_d  = cnt_q;
        end
      end
      S_WRITE: begin
        csum_d = add_mod(csum_q, data_q);
        // The counter stops at the last address; the load ends instead of wrapping.
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      wr_q    <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      wr_q    <= (state_d == S_WRITE);
      hold_q  <= (state_d != S_DONE);
      busy_q  <= (state_d == S_LOAD) || (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_wr   = wr_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader against a queue-based image model.
module tb_mem_loader;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wr;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  mem_loader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ovl   = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int tx_cyc[$];
  logic [DW-1:0] img [N];
  logic st_busy, st_done, st_hold;

  function automatic int ref_sum();
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(img[k]);
    return s % 256;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_wr === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_data));
      wr_cyc.push_back(cyc);
    end
    if (mem_wr === 1'b1 && in_ready === 1'b1) ovl++;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); tx_cyc.delete();
    ovl = 0;
  endtask

  task automatic xfer(input logic [DW-1:0] w, input bit pulse_start);
    int budget;
    budget   = 20;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && budget > 0) begin
      cycle();
      budget--;
    end
    if (in_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL xfer_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      start = pulse_start;
      cycle();
      tx_cyc.push_back(cyc);
      start = 1'b0;
    end
  endtask

  task automatic load_image(input int gap, input int start_k);
    clear_log();
    start = 1'b1;
    cycle();
    start = 1'b0;
    st_busy = busy; st_done = done; st_hold = cpu_hold;
    for (int k = 0; k < N; k++) begin
      xfer(img[k], k == start_k);
      in_valid = (gap == 0);
      for (int g = 0; g < gap; g++) cycle();
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) cycle();
    tests++;
    if ({in_ready, mem_wr, busy, done, cpu_hold, checksum, mem_addr, mem_data} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'h00}) begin
      fails++;
      $display("FAIL reset_values: rdy=%b wr=%b busy=%b done=%b hold=%b cs=%h a=%0d d=%h, required 0 0 0 0 1 00 0 00",
               in_ready, mem_wr, busy, done, cpu_hold, checksum, mem_addr, mem_data);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'($urandom);
      cycle();
      tests++;
      if ({in_ready, mem_wr, busy, done, cpu_hold, checksum} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
        fails++;
        $display("FAIL idle_no_accept[%0d]: rdy=%b wr=%b busy=%b done=%b hold=%b cs=%h, required 0 0 0 0 1 00",
                 i, in_ready, mem_wr, busy, done, cpu_hold, checksum);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load();
    for (int k = 0; k < N; k++) img[k] = DW'(k);
    load_image(0, -1);
    tests++;
    if ({st_busy, st_done, st_hold} !== 3'b101) begin
      fails++; $display("FAIL full_after_start: busy/done/hold=%b%b%b, required 101", st_busy, st_done, st_hold);
    end
    tests++;
    if (wr_addr.size() != N) begin
      fails++; $display("FAIL full_write_count: got %0d, required %0d", wr_addr.size(), N);
    end
    for (int k = 0; k < N && k < wr_addr.size(); k++) begin
      tests++;
      if (wr_addr[k] != k || wr_data[k] != int'(img[k]) || wr_cyc[k] != tx_cyc[k] ||
          (k > 0 && wr_cyc[k] - wr_cyc[k-1] != 2)) begin
        fails++;
        $display("FAIL full_write[%0d]: addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d spacing 2",
                 k, wr_addr[k], wr_data[k], wr_cyc[k], k, img[k], tx_cyc[k]);
      end
    end
    tests++;
    if (ovl != 0) begin fails++; $display("FAIL full_wr_and_ready: overlaps=%0d, required 0", ovl); end
    tests++;
    if ({done, cpu_hold, busy, in_ready, checksum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'(ref_sum())} || checksum !== 8'hF0) begin
      fails++;
      $display("FAIL full_done: done=%b hold=%b busy=%b rdy=%b cs=%h, required 1 0 0 0 %h",
               done, cpu_hold, busy, in_ready, checksum, 8'(ref_sum()));
    end
  endtask

  task automatic test_gapped();
    for (int k = 0; k < N; k++) img[k] = DW'(k);
    load_image(3, -1);
    tests++;
    if (wr_addr.size() != N) begin
      fails++; $display("FAIL gap_write_count: got %0d, required %0d", wr_addr.size(), N);
    end
    for (int k = 0; k < N && k < wr_addr.size(); k++) begin
      tests++;
      if (wr_addr[k] != k || wr_data[k] != int'(img[k]) || wr_cyc[k] != tx_cyc[k]) begin
        fails++;
        $display("FAIL gap_write[%0d]: addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d",
                 k, wr_addr[k], wr_data[k], wr_cyc[k], k, img[k], tx_cyc[k]);
      end
    end
    tests++;
    if ({done, cpu_hold, checksum} !== {1'b1, 1'b0, 8'(ref_sum())}) begin
      fails++; $display("FAIL gap_done: done=%b hold=%b cs=%h, required 1 0 %h", done, cpu_hold, checksum, 8'(ref_sum()));
    end
  endtask

  task automatic test_checksum_wrap();
    for (int k = 0; k < N; k++) img[k] = 8'hFF;
    load_image(0, -1);
    tests++;
    if (wr_data.size() != N) begin
      fails++; $display("FAIL wrap_write_count: got %0d, required %0d", wr_data.size(), N);
    end
    for (int k = 0; k < wr_data.size(); k++) begin
      tests++;
      if (wr_data[k] != 'hFF || wr_addr[k] != k) begin
        fails++; $display("FAIL wrap_write[%0d]: addr=%0d data=%0h, required addr=%0d data=ff", k, wr_addr[k], wr_data[k], k);
      end
    end
    tests++;
    if (checksum !== 8'hE0 || done !== 1'b1) begin
      fails++; $display("FAIL wrap_checksum: cs=%h done=%b, required e0 1", checksum, done);
    end
  endtask

  task automatic test_ignored_start();
    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    load_image($urandom_range(0, 2), 10);
    tests++;
    if (wr_addr.size() != N) begin
      fails++; $display("FAIL ign_write_count: got %0d, required %0d", wr_addr.size(), N);
    end
    for (int k = 0; k < N && k < wr_addr.size(); k++) begin
      tests++;
      if (wr_addr[k] != k || wr_data[k] != int'(img[k])) begin
        fails++;
        $display("FAIL ign_write[%0d]: addr=%0d data=%0h, required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, img[k]);
      end
    end
    tests++;
    if ({done, cpu_hold, checksum} !== {1'b1, 1'b0, 8'(ref_sum())}) begin
      fails++; $display("FAIL ign_done: done=%b hold=%b cs=%h, required 1 0 %h", done, cpu_hold, checksum, 8'(ref_sum()));
    end
  endtask

  task automatic test_restart();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL restart_pre_done: done=%b, required 1", done);
    end
    for (int k = 0; k < N; k++) img[k] = 8'hA5;
    load_image(0, -1);
    tests++;
    if ({st_done, st_hold, st_busy} !== 3'b011) begin
      fails++; $display("FAIL restart_after_start: done/hold/busy=%b%b%b, required 011", st_done, st_hold, st_busy);
    end
    tests++;
    if (wr_addr.size() != N) begin
      fails++; $display("FAIL restart_write_count: got %0d, required %0d", wr_addr.size(), N);
    end
    for (int k = 0; k < N && k < wr_addr.size(); k++) begin
      tests++;
      if (wr_addr[k] != k || wr_data[k] != 'hA5) begin
        fails++; $display("FAIL restart_write[%0d]: addr=%0d data=%0h, required addr=%0d data=a5", k, wr_addr[k], wr_data[k], k);
      end
    end
    tests++;
    if (checksum !== 8'hA0 || done !== 1'b1 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL restart_done: cs=%h done=%b hold=%b, required a0 1 0", checksum, done, cpu_hold);
    end
  endtask

  task automatic test_random_images();
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < N; k++) img[k] = DW'($urandom);
      load_image($urandom_range(0, 2), -1);
      tests++;
      if (wr_addr.size() != N) begin
        fails++; $display("FAIL rand%0d_write_count: got %0d, required %0d", it, wr_addr.size(), N);
      end
      for (int k = 0; k < N && k < wr_addr.size(); k++) begin
        tests++;
        if (wr_addr[k] != k || wr_data[k] != int'(img[k])) begin
          fails++;
          $display("FAIL rand%0d_write[%0d]: addr=%0d data=%0h, required addr=%0d data=%0h",
                   it, k, wr_addr[k], wr_data[k], k, img[k]);
        end
      end
      tests++;
      if ({done, cpu_hold, checksum, ovl != 0} !== {1'b1, 1'b0, 8'(ref_sum()), 1'b0}) begin
        fails++;
        $display("FAIL rand%0d_done: done=%b hold=%b cs=%h ovl=%0d, required 1 0 %h 0",
                 it, done, cpu_hold, checksum, ovl, 8'(ref_sum()));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    clear_log();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      xfer(img[k], 1'b0);
      if (k < 5) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests++;
    if (mem_wr !== 1'b1 || mem_addr !== 5'd5 || mem_data !== img[5]) begin
      fails++; $display("FAIL midrst_pre_write: wr=%b addr=%0d data=%h, required 1 5 %h", mem_wr, mem_addr, mem_data, img[5]);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({mem_wr, in_ready, busy, done, cpu_hold, checksum} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL midrst_async: wr=%b rdy=%b busy=%b done=%b hold=%b cs=%h, required 0 0 0 0 1 00",
               mem_wr, in_ready, busy, done, cpu_hold, checksum);
    end
    repeat (2) cycle();
    rst = 1'b1;
    in_valid = 1'b1;
    cycle();
    tests++;
    if ({in_ready, mem_wr, done, cpu_hold, checksum} !== {1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL midrst_idle: rdy=%b wr=%b done=%b hold=%b cs=%h, required 0 0 0 1 00",
               in_ready, mem_wr, done, cpu_hold, checksum);
    end
    in_valid = 1'b0;
    load_image(0, -1);
    tests++;
    if (wr_addr.size() != N) begin
      fails++; $display("FAIL midrst_reload_count: got %0d, required %0d", wr_addr.size(), N);
    end
    for (int k = 0; k < N && k < wr_addr.size(); k++) begin
      tests++;
      if (wr_addr[k] != k || wr_data[k] != int'(img[k])) begin
        fails++;
        $display("FAIL midrst_reload[%0d]: addr=%0d data=%0h, required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, img[k]);
      end
    end
    tests++;
    if ({done, cpu_hold, checksum} !== {1'b1, 1'b0, 8'(ref_sum())}) begin
      fails++; $display("FAIL midrst_done: done=%b hold=%b cs=%h, required 1 0 %h", done, cpu_hold, checksum, 8'(ref_sum()));
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gapped();
    test_checksum_wrap();
    test_ignored_start();
    test_restart();
    test_random_images();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time program loader that sits directly upstream of the VeriRISC core and its 32x8 single-port memory.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive memory addresses starting at 0.
- Keeps a running 8-bit checksum of the loaded bytes.
- Holds the core in reset until the full image is written, then releases it.

Parameters:
AWIDTH, 5, memory address width; image length is 2**AWIDTH words
DWIDTH, 8, memory data width and stream byte width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a new load
in_valid  input  1  stream word valid
in_data  input  DWIDTH  stream word
in_ready  output  1  loader can accept a word this cycle
mem_addr  output  AWIDTH  memory write address
mem_data  output  DWIDTH  memory write data
mem_wr  output  1  memory write strobe, one cycle per word
cpu_hold  output  1  high while the core must be held in reset; active-high
busy  output  1  load in progress
done  output  1  image fully written; stays high until the next start
checksum  output  DWIDTH  modulo-2**DWIDTH sum of all words accepted in the current load

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, busy=0, done=0, checksum=0.
  - cpu_hold=1.
  - Word counter = 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, cpu_hold=1.
  - start=1 -> LOAD; counter cleared to 0, checksum cleared to 0.
  - A word offered in the same cycle as start is not accepted.
- LOAD:
  - in_ready=1, busy=1.
  - Transfer occurs when in_valid && in_ready. On transfer: latch in_data into mem_data, drive mem_addr=counter, go to WRITE.
  - in_valid low -> remain in LOAD; no other state changes.
- WRITE:
  - Lasts exactly one cycle: mem_wr=1, in_ready=0, busy=1.
  - checksum <= checksum + mem_data, truncated to DWIDTH.
  - If counter == 2**AWIDTH-1 -> DONE. Otherwise counter <= counter+1 and go to LOAD.
  - Counter never wraps inside a load.
- DONE:
  - done=1, busy=0, in_ready=0, cpu_hold=0.
  - checksum, mem_addr and mem_data hold their last values.
  - start=1 -> LOAD: done drops, cpu_hold=1 in the next cycle, counter and checksum cleared.
- Throughput: at most one word per 2 cycles. First mem_wr occurs 1 cycle after the first accepted transfer.
- Full image: 32 transfers produce 32 write pulses, at addresses 0..31 in order.
- start while in LOAD or WRITE: ignored; the load continues unaffected.
- mem_wr is high only in WRITE. mem_wr and in_ready are never both high.
- cpu_hold is registered and glitch-free. It deasserts in the cycle DONE is entered.
- Reset asserted mid-load:
  - Immediate return to IDLE; cpu_hold=1, done=0.
  - A pending write is abandoned; mem_wr drops asynchronously.
  - Memory contents are not cleared.
- All outputs are registered except in_ready, which decodes the state register only (no input paths).

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, offer in_valid=1 with start=0 for 10 cycles -> in_ready=0, mem_wr=0, cpu_hold=1, done=0, checksum=0 throughout.
- Full load: pulse start, then stream 32 words 0x00..0x1F with in_valid held high -> exactly 32 mem_wr pulses, each at mem_addr=k with mem_data=k, spaced 2 cycles apart. Then done=1, cpu_hold=0, checksum=0xF0 (sum 496 mod 256).
- Gapped stream: same image with in_valid low for 3 cycles between every word -> identical writes and checksum; no write occurs while in_valid is low.
- Checksum wrap: stream 32 words of 0xFF -> checksum=0xE0; all mem_data=0xFF.
- Restart and ignored start:
  - Pulse start during word 10 of a load -> no effect; 32 writes still complete.
  - Pulse start in DONE -> done=0 and cpu_hold=1 next cycle; second image 0xA5 x32 writes addresses 0..31 with checksum=0xA0.
- Reset mid-load: assert rst low during the WRITE cycle of word 5 -> mem_wr falls immediately and the state returns to IDLE. After release: cpu_hold=1, done=0, checksum=0, and a new start reloads from address 0.
